// File: rtl/fft_pkg.sv
// Shared definitions for the streaming radix-2 FFT stages: rotation modes,
// a wide complex pair type and the output-width helper.
package fft_pkg;

    typedef enum int unsigned {
        TW_NONE  = 0,
        TW_NEG_J = 1
    } tw_mode_e;

    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
    } cplx_t;

    // One guard bit for the butterfly growth, given back when scaling.
    function automatic int unsigned out_w(int unsigned data_w, int unsigned scale);
        return data_w + 1 - scale;
    endfunction

endpackage

// File: rtl/fft_r2_sdf_stage_if.sv
// Sample stream into and out of one radix-2 SDF butterfly stage.
interface fft_r2_sdf_stage_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LOG2_D = 2,
    parameter int unsigned SCALE  = 0
);
    localparam int unsigned OUT_W = fft_pkg::out_w(DATA_W, SCALE);

    logic                     in_valid;
    logic                     in_sof;
    logic signed [DATA_W-1:0] in_re;
    logic signed [DATA_W-1:0] in_im;
    logic                     out_valid;
    logic                     out_sof;
    logic signed [OUT_W-1:0]  out_re;
    logic signed [OUT_W-1:0]  out_im;
    logic [LOG2_D:0]          out_idx;

    modport master (
        output in_valid, in_sof, in_re, in_im,
        input  out_valid, out_sof, out_re, out_im, out_idx
    );

    modport slave (
        input  in_valid, in_sof, in_re, in_im,
        output out_valid, out_sof, out_re, out_im, out_idx
    );

endinterface

// File: rtl/fft_r2_sdf_stage_cplx_delay_line.sv
// Fixed-depth complex delay line; shifts only when enabled, holds through stalls.
module cplx_delay_line #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 17
) (
    input  logic           clk,
    input  logic           en,
    input  logic [2*W-1:0] din,
    output logic [2*W-1:0] dout
);

    logic [2*W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/fft_r2_sdf_stage.sv
// Radix-2 DIF butterfly stage in single-path delay-feedback form, span D = 2**LOG2_D,
// with optional -j rotation of the upper-half differences and optional 1-bit scaling.
module fft_r2_sdf_stage
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned LOG2_D  = 2,
    parameter int unsigned TW_MODE = 0,
    parameter int unsigned SCALE   = 0
) (
    input logic               clk,
    input logic               rst,
    fft_r2_sdf_stage_if.slave bus
);

    localparam int unsigned D     = 1 << LOG2_D;
    localparam int unsigned IW    = DATA_W + 1;
    localparam int unsigned OUT_W = out_w(DATA_W, SCALE);
    localparam int unsigned CW    = LOG2_D + 1;

    localparam logic [CW-1:0] LAST_A  = CW'(D - 1);
    localparam logic [CW-1:0] FIRST_B = CW'(D);
    localparam logic [CW-1:0] LAST_B  = CW'(2 * D - 1);

    typedef struct packed {
        logic signed [IW-1:0] re;
        logic signed [IW-1:0] im;
    } samp_t;

    logic [CW-1:0] cnt;
    logic          pend;
    logic          sof_arm;

    logic [CW-1:0] cnt_eff;
    logic          pend_eff;
    logic          phase_b;
    logic          pend_next;
    logic          sof_eff;
    logic          first_sum;
    logic          sof_arm_next;
    logic          rot_sel;

    samp_t x_ext;
    samp_t dl_in;
    samp_t dl_out;
    samp_t sum;
    samp_t diff;
    samp_t res;

    logic signed [OUT_W-1:0] re_d;
    logic signed [OUT_W-1:0] im_d;

    logic                    out_valid_q;
    logic                    out_sof_q;
    logic signed [OUT_W-1:0] out_re_q;
    logic signed [OUT_W-1:0] out_im_q;
    logic [CW-1:0]           out_idx_q;

    // A frame start restarts the block; only an unaligned one throws away pending differences.
    always_comb begin
        cnt_eff  = bus.in_sof ? '0 : cnt;
        pend_eff = pend & ~(bus.in_sof & (cnt != '0));
        phase_b  = cnt_eff[LOG2_D];
    end

    always_comb begin
        pend_next = pend_eff;
        if (cnt_eff == LAST_B) begin
            pend_next = 1'b1;
        end else if (cnt_eff == LAST_A) begin
            pend_next = 1'b0;
        end
    end

    always_comb begin
        sof_eff      = sof_arm | bus.in_sof;
        first_sum    = (cnt_eff == FIRST_B);
        sof_arm_next = first_sum ? 1'b0 : sof_eff;
    end

    always_comb begin
        x_ext.re = {bus.in_re[DATA_W-1], bus.in_re};
        x_ext.im = {bus.in_im[DATA_W-1], bus.in_im};
        sum.re   = dl_out.re + x_ext.re;
        sum.im   = dl_out.im + x_ext.im;
        diff.re  = dl_out.re - x_ext.re;
        diff.im  = dl_out.im - x_ext.im;
        dl_in    = phase_b ? diff : x_ext;
    end

    cplx_delay_line #(
        .DEPTH (D),
        .W     (IW)
    ) u_delay (
        .clk  (clk),
        .en   (bus.in_valid),
        .din  (dl_in),
        .dout (dl_out)
    );

    if (tw_mode_e'(TW_MODE) == TW_NEG_J) begin : g_rot
        assign rot_sel = ~phase_b & cnt_eff[LOG2_D-1];
    end else begin : g_norot
        assign rot_sel = 1'b0;
    end

    // Differences leave the delay line during phase A; -j maps (re,im) to (im,-re).
    always_comb begin
        res = dl_out;
        if (phase_b) begin
            res = sum;
        end else if (rot_sel) begin
            res.re = dl_out.im;
            res.im = -dl_out.re;
        end
        re_d = OUT_W'(res.re >>> SCALE);
        im_d = OUT_W'(res.im >>> SCALE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            pend        <= 1'b0;
            sof_arm     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_idx_q   <= '0;
        end else begin
            out_valid_q <= bus.in_valid & (phase_b | pend_eff);
            out_sof_q   <= bus.in_valid & first_sum & sof_eff;
            if (bus.in_valid) begin
                cnt       <= cnt_eff + 1'b1;
                pend      <= pend_next;
                sof_arm   <= sof_arm_next;
                out_re_q  <= re_d;
                out_im_q  <= im_d;
                out_idx_q <= cnt_eff;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign bus.out_idx   = out_idx_q;

endmodule

// File: tb/tb_fft_r2_sdf_stage.sv
// Drives one shared stream into five differently configured stages and checks each
// against a block-level butterfly model.
module tb_fft_r2_sdf_stage;
    import fft_pkg::*;

    localparam int NC = 5;

    typedef struct {
        int cfg;
        int re;
        int im;
        int idx;
        bit sof;
    } cap_t;

    int cfg_l2d [NC] = '{1, 1, 0, 2, 2};
    bit cfg_tw  [NC] = '{1, 1, 0, 1, 0};
    bit cfg_sc  [NC] = '{0, 1, 0, 0, 1};

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_sof;
    logic signed [15:0] in_re;
    logic signed [15:0] in_im;

    always #5 clk = ~clk;

    fft_r2_sdf_stage_if #(.DATA_W(16), .LOG2_D(1), .SCALE(0)) if0 ();
    fft_r2_sdf_stage_if #(.DATA_W(16), .LOG2_D(1), .SCALE(1)) if1 ();
    fft_r2_sdf_stage_if #(.DATA_W(16), .LOG2_D(0), .SCALE(0)) if2 ();
    fft_r2_sdf_stage_if #(.DATA_W(16), .LOG2_D(2), .SCALE(0)) if3 ();
    fft_r2_sdf_stage_if #(.DATA_W(16), .LOG2_D(2), .SCALE(1)) if4 ();

    assign if0.in_valid = in_valid; assign if0.in_sof = in_sof; assign if0.in_re = in_re; assign if0.in_im = in_im;
    assign if1.in_valid = in_valid; assign if1.in_sof = in_sof; assign if1.in_re = in_re; assign if1.in_im = in_im;
    assign if2.in_valid = in_valid; assign if2.in_sof = in_sof; assign if2.in_re = in_re; assign if2.in_im = in_im;
    assign if3.in_valid = in_valid; assign if3.in_sof = in_sof; assign if3.in_re = in_re; assign if3.in_im = in_im;
    assign if4.in_valid = in_valid; assign if4.in_sof = in_sof; assign if4.in_re = in_re; assign if4.in_im = in_im;

    fft_r2_sdf_stage #(.DATA_W(16), .LOG2_D(1), .TW_MODE(1), .SCALE(0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    fft_r2_sdf_stage #(.DATA_W(16), .LOG2_D(1), .TW_MODE(1), .SCALE(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    fft_r2_sdf_stage #(.DATA_W(16), .LOG2_D(0), .TW_MODE(0), .SCALE(0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
    fft_r2_sdf_stage #(.DATA_W(16), .LOG2_D(2), .TW_MODE(1), .SCALE(0)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));
    fft_r2_sdf_stage #(.DATA_W(16), .LOG2_D(2), .TW_MODE(0), .SCALE(1)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

    logic act_v   [NC];
    logic act_sof [NC];
    int   act_re  [NC];
    int   act_im  [NC];
    int   act_idx [NC];

    always_comb begin
        act_v[0] = if0.out_valid; act_sof[0] = if0.out_sof; act_re[0] = int'(if0.out_re); act_im[0] = int'(if0.out_im); act_idx[0] = int'(if0.out_idx);
        act_v[1] = if1.out_valid; act_sof[1] = if1.out_sof; act_re[1] = int'(if1.out_re); act_im[1] = int'(if1.out_im); act_idx[1] = int'(if1.out_idx);
        act_v[2] = if2.out_valid; act_sof[2] = if2.out_sof; act_re[2] = int'(if2.out_re); act_im[2] = int'(if2.out_im); act_idx[2] = int'(if2.out_idx);
        act_v[3] = if3.out_valid; act_sof[3] = if3.out_sof; act_re[3] = int'(if3.out_re); act_im[3] = int'(if3.out_im); act_idx[3] = int'(if3.out_idx);
        act_v[4] = if4.out_valid; act_sof[4] = if4.out_sof; act_re[4] = int'(if4.out_re); act_im[4] = int'(if4.out_im); act_idx[4] = int'(if4.out_idx);
    end

    // Model state: first-half samples of the current block, its differences, and the
    // previous block's differences still waiting to be emitted.
    cplx_t xa [NC][4];
    cplx_t cd [NC][4];
    cplx_t pd [NC][4];
    bit    have_prev [NC];
    int    pos [NC];
    bit    armed [NC];

    logic e_v   [NC];
    logic e_sof [NC];
    int   e_re  [NC];
    int   e_im  [NC];
    int   e_idx [NC];

    cap_t cap [$];
    int vectors = 0;
    int miscompares = 0;

    function automatic void model_reset();
        for (int c = 0; c < NC; c++) begin
            pos[c] = 0; have_prev[c] = 0; armed[c] = 0;
            e_v[c] = 0; e_sof[c] = 0; e_re[c] = 0; e_im[c] = 0; e_idx[c] = 0;
        end
    endfunction

    function automatic void emit(int c, int re, int im, int idx);
        e_v[c]   = 1;
        e_re[c]  = cfg_sc[c] ? (re >>> 1) : re;
        e_im[c]  = cfg_sc[c] ? (im >>> 1) : im;
        e_idx[c] = idx;
    endfunction

    function automatic void model(int c, bit v, bit s, int re, int im);
        int d = 1 << cfg_l2d[c];
        int k;
        int orr;
        int oi;
        int t;
        e_v[c] = 0;
        e_sof[c] = 0;
        if (!v) return;
        if (s) begin
            if (pos[c] != 0) have_prev[c] = 0;
            pos[c] = 0;
            armed[c] = 1;
        end
        if (pos[c] < d) begin
            k = pos[c];
            xa[c][k].re = re;
            xa[c][k].im = im;
            if (have_prev[c]) begin
                orr = int'(pd[c][k].re);
                oi  = int'(pd[c][k].im);
                if (cfg_tw[c] && k >= d / 2) begin
                    t = orr; orr = oi; oi = -t;
                end
                emit(c, orr, oi, pos[c]);
            end
            if (k == d - 1) have_prev[c] = 0;
        end else begin
            k = pos[c] - d;
            emit(c, int'(xa[c][k].re) + re, int'(xa[c][k].im) + im, pos[c]);
            cd[c][k].re = int'(xa[c][k].re) - re;
            cd[c][k].im = int'(xa[c][k].im) - im;
            if (k == 0) begin
                e_sof[c] = armed[c];
                armed[c] = 0;
            end
            if (k == d - 1) begin
                for (int j = 0; j < d; j++) pd[c][j] = cd[c][j];
                have_prev[c] = 1;
            end
        end
        pos[c] = (pos[c] + 1) % (2 * d);
    endfunction

    task automatic check_all();
        for (int c = 0; c < NC; c++) begin
            vectors++;
            assert (act_v[c] === e_v[c]) else begin
                miscompares++;
                $error("FAIL valid cfg%0d: got %b expected %b", c, act_v[c], e_v[c]);
            end
            vectors++;
            assert (act_sof[c] === e_sof[c]) else begin
                miscompares++;
                $error("FAIL sof cfg%0d: got %b expected %b", c, act_sof[c], e_sof[c]);
            end
            if (e_v[c]) begin
                vectors++;
                assert (act_re[c] === e_re[c] && act_im[c] === e_im[c] && act_idx[c] === e_idx[c]) else begin
                    miscompares++;
                    $error("FAIL data cfg%0d: got (%0d,%0d) idx %0d expected (%0d,%0d) idx %0d",
                           c, act_re[c], act_im[c], act_idx[c], e_re[c], e_im[c], e_idx[c]);
                end
            end
            if (act_v[c] === 1'b1) cap.push_back('{c, act_re[c], act_im[c], act_idx[c], act_sof[c]});
        end
    endtask

    task automatic step(bit v, bit s, int re, int im);
        in_valid = v;
        in_sof   = s;
        in_re    = 16'(re);
        in_im    = 16'(im);
        for (int c = 0; c < NC; c++) model(c, v, s, re, im);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic check_zero(string tag);
        for (int c = 0; c < NC; c++) begin
            vectors++;
            assert (act_v[c] === 1'b0 && act_sof[c] === 1'b0 && act_re[c] === 0 && act_im[c] === 0 && act_idx[c] === 0) else begin
                miscompares++;
                $error("FAIL %s cfg%0d: got v=%b sof=%b (%0d,%0d) idx %0d expected all zero",
                       tag, c, act_v[c], act_sof[c], act_re[c], act_im[c], act_idx[c]);
            end
        end
    endtask

    task automatic do_reset(bit v);
        rst = 1;
        in_valid = v;
        in_sof = 0;
        in_re = 16'($urandom);
        in_im = 16'($urandom);
        @(posedge clk);
        #1;
        check_zero("reset");
        rst = 0;
        model_reset();
        cap.delete();
    endtask

    task automatic kat(string tag, int c, int n, int re, int im, int idx, bit sof);
        cap_t r = '{default: 0};
        int seen = 0;
        bit found = 0;
        foreach (cap[i]) begin
            if (!found && cap[i].cfg == c) begin
                if (seen == n) begin
                    r = cap[i];
                    found = 1;
                end
                seen++;
            end
        end
        vectors++;
        assert (found && r.re === re && r.im === im && r.idx === idx && r.sof === sof) else begin
            miscompares++;
            $error("FAIL %s: got present=%0d (%0d,%0d) idx %0d sof %0d expected (%0d,%0d) idx %0d sof %0d",
                   tag, found, r.re, r.im, r.idx, r.sof, re, im, idx, sof);
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        int seq [8] = '{1, 2, 3, 4, 0, 0, 0, 0};
        rst = 1; in_valid = 0; in_sof = 0; in_re = 0; in_im = 0;
        model_reset();
        @(posedge clk);
        do_reset(0);

        // Ramp with continuous valid.
        foreach (seq[i]) step(1, i == 0, seq[i], 0);
        kat("ramp_sum0", 0, 0, 4, 0, 2, 1);
        kat("ramp_sum1", 0, 1, 6, 0, 3, 0);
        kat("ramp_dif0", 0, 2, -2, 0, 0, 0);
        kat("ramp_dif1", 0, 3, 0, 2, 1, 0);

        // Same ramp with a bubble after every sample.
        do_reset(0);
        foreach (seq[i]) begin
            step(1, i == 0, seq[i], 0);
            step(0, 0, rnd16(), rnd16());
        end
        kat("gap_sum0", 0, 0, 4, 0, 2, 1);
        kat("gap_sum1", 0, 1, 6, 0, 3, 0);
        kat("gap_dif0", 0, 2, -2, 0, 0, 0);
        kat("gap_dif1", 0, 3, 0, 2, 1, 0);

        // Full-scale extremes.
        do_reset(0);
        step(1, 1, -32768, 0);
        step(1, 0, 0, 0);
        step(1, 0, 32767, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        kat("ext_sum", 0, 0, -1, 0, 2, 1);
        kat("ext_dif", 0, 2, -65535, 0, 0, 0);
        kat("ext_sum_scaled", 1, 0, -1, 0, 2, 1);
        kat("ext_dif_scaled", 1, 2, -32768, 0, 0, 0);

        // Span of one.
        do_reset(0);
        step(1, 1, 5, -3);
        step(1, 0, 1, 1);
        step(1, 0, 0, 0);
        kat("d1_sum", 2, 0, 6, -2, 1, 1);
        kat("d1_dif", 2, 1, 4, -4, 0, 0);

        // Unaligned frame start while a previous block's differences are draining.
        do_reset(0);
        for (int i = 0; i < 8; i++) step(1, i == 0, rnd16(), rnd16());
        for (int i = 0; i < 3; i++) step(1, 0, rnd16(), rnd16());
        for (int i = 0; i < 8; i++) step(1, i == 0, rnd16(), rnd16());
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);

        // Reset in the middle of a frame, then a clean frame.
        do_reset(0);
        for (int i = 0; i < 6; i++) step(1, i == 0, rnd16(), rnd16());
        do_reset(1);
        for (int i = 0; i < 8; i++) step(1, i == 0, rnd16(), rnd16());
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);

        // Random stalls, data and occasional frame starts.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 23) == 0, rnd16(), rnd16());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
